shiftregist_sipo_rx: RTL and testbench



---
 rtl/shiftregist_sipo_rx.sv | 99 +++++++++
 tb/tb_shiftregist_sipo_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shiftregist_sipo_rx.sv
// rtl/shiftregist_sipo_rx.sv - serial-in parallel-out receiver with valid/ready word output
module shiftregist_sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] word;
    logic             complete;
    logic             accept;
    logic             drop;

    // The completing bit never enters sr; it is merged straight into the word.
    always_comb begin
        word     = {sr, sin};
        complete = (state == SHIFT) && sin_valid && !sin_start && (cnt == LAST);
        accept   = complete && (!dout_valid || dout_ready);
        drop     = complete && dout_valid && !dout_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sin_valid && sin_start) begin
                        sr    <= (WIDTH-1)'(sin);
                        cnt   <= CW'(1);
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sin_valid) begin
                        if (sin_start) begin
                            sr  <= (WIDTH-1)'(sin);
                            cnt <= CW'(1);
                        end else if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            sr  <= word[WIDTH-2:0];
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (accept) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear must still be reported.
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shiftregist_sipo_rx.sv
// tb/tb_shiftregist_sipo_rx.sv - directed self-checking bench for shiftregist_sipo_rx
module tb_shiftregist_sipo_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic       sin_start;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       overrun;
    logic       ovr_clr;

    int checks = 0;
    int errors = 0;

    shiftregist_sipo_rx #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_start  (sin_start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic s, input logic b);
        sin_valid = v;
        sin_start = s;
        sin       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, w[3-i]);
        sin_valid = 1'b0;
        sin_start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dout !== 4'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b exp 0", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_frame;
        drive(1'b1, 1'b1, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_b1 got %b exp 1", busy); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_b2 got %b exp 1", busy); end
        drive(1'b1, 1'b0, 1'b1);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL frame_early_valid got %b exp 0", dout_valid); end
        drive(1'b1, 1'b0, 1'b1);
        sin_valid = 1'b0;
        checks++; if (dout !== 4'b1011) begin errors++; $display("FAIL frame_dout got %b exp 1011", dout); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %b exp 1", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_done got %b exp 0", busy); end
        dout_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        dout_ready = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL consume_valid got %b exp 0", dout_valid); end
        checks++; if (dout !== 4'b1011) begin errors++; $display("FAIL consume_dout_kept got %b exp 1011", dout); end
    endtask

    task automatic test_gapped;
        logic [3:0] w;
        w = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, w[3-i]);
            if (i < 3) begin
                // Unqualified start/data during a gap must be ignored.
                drive(1'b0, 1'b1, 1'b1);
                drive(1'b0, 1'b0, 1'b1);
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy_%0d got %b exp 1", i, busy); end
            end
        end
        sin_valid = 1'b0;
        checks++; if (dout !== 4'b1100) begin errors++; $display("FAIL gap_dout got %b exp 1100", dout); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b exp 1", dout_valid); end
        dout_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        dout_ready = 1'b0;
    endtask

    task automatic test_restart;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b exp 1", busy); end
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL restart_early_valid got %b exp 0", dout_valid); end
        drive(1'b1, 1'b0, 1'b0);
        sin_valid = 1'b0;
        checks++; if (dout !== 4'b0110) begin errors++; $display("FAIL restart_dout got %b exp 0110", dout); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL restart_valid got %b exp 1", dout_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL restart_overrun got %b exp 0", overrun); end
        dout_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        dout_ready = 1'b0;
    endtask

    task automatic test_overrun;
        send_word(4'hA);
        checks++; if (dout !== 4'hA) begin errors++; $display("FAIL ovr_first_dout got %h exp a", dout); end
        send_word(4'h5);
        checks++; if (dout !== 4'hA) begin errors++; $display("FAIL ovr_dout_kept got %h exp a", dout); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", dout_valid); end
        ovr_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        ovr_clr = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        ovr_clr = 1'b0;
        sin_valid = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
        checks++; if (dout !== 4'hA) begin errors++; $display("FAIL ovr_set_wins_dout got %h exp a", dout); end
        ovr_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        dout_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        dout_ready = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL ovr_consume_valid got %b exp 0", dout_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared_again got %b exp 0", overrun); end
        dout_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        dout_ready = 1'b0;
        checks++; if (dout_valid !== 1'b0 || dout !== 4'hA) begin errors++; $display("FAIL ready_when_empty got valid %b dout %h exp 0 a", dout_valid, dout); end
    endtask

    task automatic test_consume_and_complete;
        send_word(4'h3);
        checks++; if (dout !== 4'h3) begin errors++; $display("FAIL cc_hold_dout got %h exp 3", dout); end
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        dout_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        dout_ready = 1'b0;
        sin_valid  = 1'b0;
        checks++; if (dout !== 4'hC) begin errors++; $display("FAIL cc_dout got %h exp c", dout); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL cc_valid got %b exp 1", dout_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL cc_overrun got %b exp 0", overrun); end
    endtask

    task automatic test_async_reset;
        logic [3:0] w;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        sin_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (dout !== 4'h0) begin errors++; $display("FAIL areset_dout got %h exp 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        w = 4'b1001;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, w[3-i]);
        sin_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nostart_busy got %b exp 0", busy); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL nostart_valid got %b exp 0", dout_valid); end
        send_word(4'h9);
        checks++; if (dout !== 4'h9) begin errors++; $display("FAIL areset_frame_dout got %h exp 9", dout); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL areset_frame_valid got %b exp 1", dout_valid); end
    endtask

    task automatic test_back_to_back;
        dout_ready = 1'b1;
        send_word(4'h5);
        checks++; if (dout !== 4'h5 || dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp 5/1", dout, dout_valid); end
        send_word(4'hE);
        checks++; if (dout !== 4'hE || dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b exp e/1", dout, dout_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
        dout_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        sin_start  = 1'b0;
        dout_ready = 1'b0;
        ovr_clr    = 1'b0;
        test_reset;
        test_frame;
        test_gapped;
        test_restart;
        test_overrun;
        test_consume_and_complete;
        test_async_reset;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
